// File: rtl/pe_seq_pkg.sv
// pe_seq_pkg: shared state encoding, load-select codes and output-count helper for the conv1d sequencer
package pe_seq_pkg;
  typedef enum logic [2:0] {IDLE, F_RD, F_WR, I_RD, I_WR, START, RUN, WAIT_DONE} state_t;
  localparam logic SEL_FILTER = 1'b0;
  localparam logic SEL_IFMAP = 1'b1;
  function automatic int num_out(int depth_i, int depth_f);
    return depth_i - depth_f + 1;
  endfunction
endpackage

// File: rtl/pe_conv1d_sequencer.sv
// pe_conv1d_sequencer: loads filter/ifmap into a 1D-conv PE, feeds psum_in, forwards psum_out and guards against a hung PE
module pe_conv1d_sequencer
  import pe_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH_I = 5,
  parameter int ADDR_I = 3,
  parameter int DEPTH_F = 3,
  parameter int ADDR_F = 2,
  parameter int MEM_AW = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                go,
  input  logic [WIDTH-1:0]    cfg_bias,
  output logic                busy,
  output logic                err,
  output logic                mem_rd_en,
  output logic [MEM_AW-1:0]   mem_addr,
  input  logic [WIDTH/2-1:0]  mem_rdata,
  output logic                ld_valid,
  input  logic                ld_ready,
  output logic                ld_sel,
  output logic [ADDR_I-1:0]   ld_addr,
  output logic [WIDTH/2-1:0]  ld_data,
  output logic                start_valid,
  input  logic                start_ready,
  output logic                pin_valid,
  input  logic                pin_ready,
  output logic [WIDTH-1:0]    pin_data,
  input  logic                pout_valid,
  output logic                pout_ready,
  input  logic [WIDTH-1:0]    pout_data,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [WIDTH-1:0]    res_data,
  output logic                res_last,
  input  logic                done_valid,
  output logic                done_ready
);
  localparam int OW = WIDTH / 2;
  localparam int NUM_OUT = num_out(DEPTH_I, DEPTH_F);
  localparam int M1 = DEPTH_I > NUM_OUT ? DEPTH_I : NUM_OUT;
  localparam int CW = $clog2((M1 > TIMEOUT ? M1 : TIMEOUT) + 1);
  state_t state, state_n;
  logic [CW-1:0] idx, pin_cnt, out_cnt, wdog;
  logic [WIDTH-1:0] bias;
  logic [OW-1:0] ld_hold;
  logic rd_d, in_wd, accept, ld_xfer, ld_last, st_xfer, pin_xfer, res_xfer, done_xfer, timeout;
  assign accept = state == IDLE && go;
  assign in_wd = state == RUN || state == WAIT_DONE;
  assign busy = state != IDLE;
  assign mem_rd_en = state == F_RD || state == I_RD;
  assign mem_addr = state == I_RD ? MEM_AW'(DEPTH_F) + MEM_AW'(idx) : MEM_AW'(idx);
  assign ld_valid = state == F_WR || state == I_WR;
  assign ld_sel = state == I_WR ? SEL_IFMAP : SEL_FILTER;
  assign ld_addr = state == I_WR ? ADDR_I'(idx) : ADDR_I'(idx[ADDR_F-1:0]);
  assign ld_data = rd_d ? mem_rdata : ld_hold;
  assign start_valid = state == START;
  assign pin_valid = state == RUN && pin_cnt < CW'(NUM_OUT);
  assign pin_data = bias;
  assign pout_ready = state == RUN && res_ready;
  assign res_valid = state == RUN && pout_valid;
  assign res_data = pout_data;
  assign res_last = state == RUN && out_cnt == CW'(NUM_OUT - 1);
  assign done_ready = state == WAIT_DONE;
  assign ld_xfer = ld_valid && ld_ready;
  assign ld_last = idx == (state == I_WR ? CW'(DEPTH_I - 1) : CW'(DEPTH_F - 1));
  assign st_xfer = start_valid && start_ready;
  assign pin_xfer = pin_valid && pin_ready;
  assign res_xfer = res_valid && res_ready;
  assign done_xfer = done_valid && done_ready;
  assign timeout = in_wd && !(pin_xfer || res_xfer || done_xfer) && wdog == CW'(TIMEOUT - 1);
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = go ? F_RD : IDLE;
      F_RD: state_n = F_WR;
      F_WR: state_n = !ld_ready ? F_WR : ld_last ? I_RD : F_RD;
      I_RD: state_n = I_WR;
      I_WR: state_n = !ld_ready ? I_WR : ld_last ? START : I_RD;
      START: state_n = start_ready ? RUN : START;
      RUN: state_n = timeout ? IDLE : (res_xfer && out_cnt == CW'(NUM_OUT - 1)) ? WAIT_DONE : RUN;
      WAIT_DONE: state_n = (done_valid || timeout) ? IDLE : WAIT_DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      pin_cnt <= '0;
      out_cnt <= '0;
      wdog <= '0;
      bias <= '0;
      ld_hold <= '0;
      rd_d <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      rd_d <= mem_rd_en;
      ld_hold <= rd_d ? mem_rdata : ld_hold;
      bias <= accept ? cfg_bias : bias;
      idx <= state == IDLE ? '0 : ld_xfer ? (ld_last ? '0 : idx + 1'b1) : idx;
      pin_cnt <= st_xfer ? '0 : pin_xfer ? pin_cnt + 1'b1 : pin_cnt;
      out_cnt <= st_xfer ? '0 : res_xfer ? out_cnt + 1'b1 : out_cnt;
      wdog <= (st_xfer || pin_xfer || res_xfer || done_xfer) ? '0 : in_wd ? wdog + 1'b1 : wdog;
      err <= timeout ? 1'b1 : accept ? 1'b0 : err;
    end
  end
endmodule

// File: tb/tb_pe_conv1d_sequencer.sv
// tb_pe_conv1d_sequencer: table-driven and randomized jobs against a behavioural PE, memory and conv reference
module tb_pe_conv1d_sequencer;
  localparam int DF = 3;
  localparam int DI = 5;
  localparam int NO = DI - DF + 1;
  localparam int TO = 20;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic go = 1'b0;
  logic [7:0] cfg_bias = 8'd0;
  logic busy, err, mem_rd_en;
  logic [3:0] mem_addr, mem_rdata;
  logic ld_valid, ld_ready, ld_sel;
  logic [2:0] ld_addr;
  logic [3:0] ld_data;
  logic start_valid, start_ready, pin_valid, pin_ready;
  logic [7:0] pin_data;
  logic pout_valid, pout_ready;
  logic [7:0] pout_data;
  logic res_valid, res_ready, res_last;
  logic [7:0] res_data;
  logic done_valid, done_ready;
  pe_conv1d_sequencer #(.WIDTH(8), .DEPTH_I(DI), .ADDR_I(3), .DEPTH_F(DF), .ADDR_F(2), .MEM_AW(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .cfg_bias(cfg_bias), .busy(busy), .err(err),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
    .start_valid(start_valid), .start_ready(start_ready),
    .pin_valid(pin_valid), .pin_ready(pin_ready), .pin_data(pin_data),
    .pout_valid(pout_valid), .pout_ready(pout_ready), .pout_data(pout_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
    .done_valid(done_valid), .done_ready(done_ready)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [3:0] mem [16];
  always @(posedge clk) mem_rdata <= mem_rd_en ? mem[mem_addr] : 4'($urandom);
  typedef struct packed {logic sel; logic [2:0] addr; logic [3:0] data;} ld_t;
  typedef struct packed {logic [31:0] m; logic [7:0] b; logic [23:0] r;} vec_t;
  int checks = 0, failures = 0;
  int res_mode = 0, stall_left = 0, stall_seen = 0;
  bit rnd_rdy = 0, pe_silent = 0, pe_started = 0, run_phase = 0, first_seen = 0;
  logic [3:0] pf [DF];
  logic [3:0] px [DI];
  logic [7:0] pin_q [$];
  logic [7:0] res_q [$];
  ld_t exp_ld [$];
  ld_t e, first_ld;
  logic [7:0] exp_bias;
  logic [7:0] exp_res [NO];
  int np = 0, res_cnt = 0, jobs = 0, starts = 0, dones = 0, pins = 0, loads = 0, last_pin_cyc = 0;
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic logic [7:0] pe_calc(int k);
    logic [7:0] s;
    s = pin_q[k];
    for (int j = 0; j < DF; j++) s += {4'b0, pf[j]} * {4'b0, px[k+j]};
    return s;
  endfunction
  always @(posedge clk) begin
    #1;
    pin_ready = rnd_rdy ? 1'($urandom) : 1'b1;
    start_ready = rnd_rdy ? 1'($urandom) : 1'b1;
    res_ready = res_mode == 2 ? !res_ready : res_mode == 1 ? 1'($urandom) : 1'b1;
    ld_ready = (stall_left > 0 && ld_valid && !ld_sel && ld_addr == 3'd1) ? 1'b0 : rnd_rdy ? 1'($urandom) : 1'b1;
    pout_valid = pe_started && !pe_silent && np < pin_q.size() && np < NO;
    pout_data = pout_valid ? pe_calc(np) : 8'($urandom);
    done_valid = pe_started;
  end
  always @(negedge clk) begin
    if (!rst_n) begin
      pe_started = 0;
      run_phase = 0;
    end else begin
      if (err) run_phase = 0;
      if (go && !busy) begin
        jobs++;
        exp_bias = cfg_bias;
        exp_ld.delete();
        res_q.delete();
        pin_q.delete();
        np = 0;
        res_cnt = 0;
        pe_started = 0;
        first_seen = 0;
        for (int j = 0; j < DF; j++) exp_ld.push_back({1'b0, 3'(j), mem[j]});
        for (int j = 0; j < DI; j++) exp_ld.push_back({1'b1, 3'(j), mem[DF+j]});
        for (int k = 0; k < NO; k++) begin
          exp_res[k] = cfg_bias;
          for (int j = 0; j < DF; j++) exp_res[k] += {4'b0, mem[j]} * {4'b0, mem[DF+k+j]};
        end
      end
      chk("pout_ready_mirror", 32'(pout_ready), 32'(run_phase && res_ready));
      chk("res_valid_pass", 32'(res_valid), 32'(run_phase && pout_valid));
      if (res_valid) begin
        chk("res_data_pass", res_data, pout_data);
        chk("res_last", 32'(res_last), 32'(res_cnt == NO - 1));
      end
      if (ld_valid) begin
        chk("ld_expected", 32'(exp_ld.size() > 0), 1);
        if (exp_ld.size() > 0) begin
          e = exp_ld[0];
          chk("ld_sel", 32'(ld_sel), 32'(e.sel));
          chk("ld_addr", ld_addr, e.addr);
          chk("ld_data", ld_data, e.data);
          if (ld_ready) begin
            void'(exp_ld.pop_front());
            if (!first_seen) first_ld = {ld_sel, ld_addr, ld_data};
            first_seen = 1;
            if (!ld_sel && ld_addr < DF) pf[ld_addr] = ld_data;
            if (ld_sel && ld_addr < DI) px[ld_addr] = ld_data;
            loads++;
          end else if (stall_left > 0 && !ld_sel && ld_addr == 3'd1) begin
            stall_left--;
            stall_seen++;
          end
        end
      end
      if (start_valid && start_ready) begin
        starts++;
        pe_started = 1;
        run_phase = 1;
      end
      if (pin_valid && pin_ready) begin
        chk("pin_data", pin_data, exp_bias);
        chk("pin_count", 32'(pin_q.size() < NO), 1);
        pin_q.push_back(pin_data);
        pins++;
        last_pin_cyc = cyc + 1;
      end
      if (res_valid && res_ready) begin
        chk("res_count", 32'(res_cnt < NO), 1);
        if (res_cnt < NO) chk("res_ref", res_data, exp_res[res_cnt]);
        res_q.push_back(res_data);
        res_cnt++;
        np++;
        if (res_cnt == NO) run_phase = 0;
      end
      if (done_valid && done_ready) begin
        chk("done_after_results", res_cnt, NO);
        dones++;
        pe_started = 0;
      end
    end
  end
  task automatic start_job(logic [7:0] b);
    @(posedge clk);
    #1;
    cfg_bias = b;
    go = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
  endtask
  task automatic pulse_go();
    go = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
  endtask
  task automatic run_job(string name, logic [7:0] b, int mid_bias, bit busy_go);
    int j0, s0, d0, p0, l0, n;
    j0 = jobs;
    s0 = starts;
    d0 = dones;
    p0 = pins;
    l0 = loads;
    start_job(b);
    if (mid_bias >= 0) begin
      repeat (4) @(posedge clk);
      #1;
      cfg_bias = 8'(mid_bias);
    end
    if (busy_go) begin
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!(ld_valid && ld_sel) && n < 200);
      chk({name, "_reach_iwr"}, 32'(ld_valid && ld_sel), 1);
      pulse_go();
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!pin_valid && n < 200);
      chk({name, "_reach_run"}, 32'(pin_valid), 1);
      pulse_go();
    end
    n = 0;
    @(negedge clk);
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_finished"}, 32'(busy), 0);
    repeat (5) @(negedge clk);
    chk({name, "_idle_after"}, 32'(busy), 0);
    chk({name, "_jobs"}, jobs - j0, 1);
    chk({name, "_starts"}, starts - s0, 1);
    chk({name, "_dones"}, dones - d0, 1);
    chk({name, "_pins"}, pins - p0, NO);
    chk({name, "_loads"}, loads - l0, DF + DI);
    chk({name, "_results"}, res_q.size(), NO);
    chk({name, "_err"}, 32'(err), 0);
  endtask
  task automatic load_mem(logic [31:0] m);
    for (int j = 0; j < 8; j++) mem[j] = m[4*j +: 4];
  endtask
  task automatic chk_outputs_low(string name);
    chk({name, "_busy"}, 32'(busy), 0);
    chk({name, "_rd_en"}, 32'(mem_rd_en), 0);
    chk({name, "_ld_valid"}, 32'(ld_valid), 0);
    chk({name, "_start_valid"}, 32'(start_valid), 0);
    chk({name, "_pin_valid"}, 32'(pin_valid), 0);
    chk({name, "_pout_ready"}, 32'(pout_ready), 0);
    chk({name, "_res_valid"}, 32'(res_valid), 0);
    chk({name, "_res_last"}, 32'(res_last), 0);
    chk({name, "_done_ready"}, 32'(done_ready), 0);
  endtask
  initial begin
    vec_t tbl [5];
    int n;
    tbl[0] = '{32'h54321312, 8'd0, 24'h19130D};
    tbl[1] = '{32'h54321312, 8'd7, 24'h201A14};
    tbl[2] = '{32'h56789001, 8'd3, 24'h0A0B0C};
    tbl[3] = '{32'hFFFFFFFF, 8'd255, 24'hA2A2A2};
    tbl[4] = '{32'h54321100, 8'd0, 24'h050403};
    for (int i = 0; i < 16; i++) mem[i] = 4'($urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_outputs_low("reset");
    chk("reset_err", 32'(err), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      load_mem(tbl[i].m);
      run_job("table", tbl[i].b, -1, 0);
      for (int k = 0; k < NO; k++) chk("table_res", res_q.size() > k ? res_q[k] : 0, tbl[i].r[8*k +: 8]);
    end
    load_mem(tbl[0].m);
    stall_left = 4;
    stall_seen = 0;
    res_mode = 2;
    run_job("backpressure", 8'd0, -1, 0);
    chk("stall_cycles", stall_seen, 4);
    for (int k = 0; k < NO; k++) chk("bp_res", res_q.size() > k ? res_q[k] : 0, tbl[0].r[8*k +: 8]);
    res_mode = 0;
    run_job("bias", 8'd7, 9, 0);
    for (int k = 0; k < NO; k++) chk("bias_pin", pin_q.size() > k ? pin_q[k] : 0, 7);
    run_job("busy_go", 8'd0, -1, 1);
    pe_silent = 1;
    start_job(8'd5);
    n = 0;
    do begin @(negedge clk); n++; end while (!err && n < 300);
    chk("timeout_err", 32'(err), 1);
    chk("timeout_latency", cyc - last_pin_cyc, TO);
    chk_outputs_low("timeout");
    repeat (3) @(negedge clk);
    chk("timeout_sticky", 32'(err), 1);
    pe_silent = 0;
    run_job("after_timeout", 8'd0, -1, 0);
    start_job(8'd3);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!(ld_valid && ld_sel && ld_addr == 3'd2) && n < 200);
    chk("reach_iwr2", 32'(ld_valid && ld_sel && ld_addr == 3'd2), 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_outputs_low("midreset");
    chk("midreset_err", 32'(err), 0);
    run_job("after_reset", 8'd0, -1, 0);
    chk("restart_first_ld", 32'(first_ld), 32'({1'b0, 3'd0, mem[0]}));
    rnd_rdy = 1;
    res_mode = 1;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) mem[i] = 4'($urandom);
      run_job("random", 8'($urandom), -1, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #500000;
    failures++;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
